dbg_uart_dump: RTL
==================

// Module: dbg_uart_dump
// PURPOSE
//  On a trigger pulse, captures the CPU debug words (PC, IR, ALUOut, status) and streams them over UART 8N1.
//  The frame is fixed-format uppercase ASCII hex: "P=xxxxxxxx I=xxxxxxxx A=xxxxxxxx S=xxxxxxxx\r\n" (45 bytes).
//  Sits beside sev_seg_ctrl in cpu_fpga_top and consumes the same datapath_multi debug outputs.
//  trigger comes from a noise_rmv/edge_detect button pair.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency, Hz
//  BAUD          115_200      UART bit rate
//  CLKS_PER_BIT  CLK_HZ/BAUD  cycles per UART bit (integer divide; 868 at defaults; overridable, min 4)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous, active-low reset
//  trigger    in   1   one-cycle request to dump a snapshot
//  pc_dbg     in   32  PC_dbg from datapath
//  ir_dbg     in   32  IR_dbg from datapath
//  aluout_dbg in   32  ALUOut_dbg from datapath
//  status_dbg in   32  status_reg from datapath
//  uart_tx    out  1   serial line; idle high
//  busy       out  1   high from trigger acceptance until frame complete
//  done       out  1   one-cycle pulse when the last stop bit of the frame ends
// BEHAVIOUR
//  Reset (async, immediate): uart_tx=1, busy=0, done=0, all counters=0, FSM=IDLE.
//  Accept rule: trigger is accepted only in a cycle where busy==0. Triggers while busy are dropped, not queued.
//  Acceptance:
//   - All four words are latched into a 128-bit snapshot on the accepting edge.
//   - Later input changes do not affect the frame.
//   - busy=1 from the next cycle; uart_tx falls (start bit) within 2 cycles of the trigger edge.
//  Frame FSM: IDLE -> LOAD -> SEND -> (LOAD | FINISH) -> IDLE.
//   - LOAD: char_idx (0..44) selects the byte.
//     - Tag letters 'P','I','A','S' (0x50,0x49,0x41,0x53), then '=' (0x3D).
//     - Eight nibbles per word, MSB nibble first; 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
//     - ' ' (0x20) between fields; CR (0x0D) and LF (0x0A) at idx 43 and 44.
//     - LOAD asserts tx_start to the byte sender for 1 cycle.
//   - SEND: waits for tx_done. Then idx<44 -> idx+1, LOAD; idx==44 -> FINISH.
//   - FINISH (1 cycle): done=1, busy=0 in the same cycle; FSM returns to IDLE.
//   - A trigger in the FINISH cycle is accepted (busy==0 there) and starts a new frame.
//  Byte sender states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - Each state is held exactly CLKS_PER_BIT cycles.
//   - START drives 0. DATA sends 8 bits LSB first. STOP drives 1.
//   - tx_done pulses on the last STOP cycle.
//  Gaps and frame time:
//   - No gap between bytes beyond the 1-cycle LOAD, so inter-byte idle is <=2 cycles.
//   - Frame length = 45*(10*CLKS_PER_BIT + <=2) cycles.
//  Counters:
//   - Baud counter width $clog2(CLKS_PER_BIT). It reloads on every bit boundary and never free-runs in IDLE.
//   - bit_idx is 3 bits; char_idx is 6 bits; none of them wrap.
//  Reset mid-frame: line goes high immediately; the partial frame is abandoned. After release, the next trigger sends a full frame from 'P'.
//  trigger is synchronous to clk (already debounced/edge-detected); no internal synchroniser.
// STRUCTURE
//  dbg_pkg: ASCII constants (ASCII_P/I/A/S/EQ/SP/CR/LF), FRAME_LEN=45, function hex_ascii(logic [3:0]) -> logic [7:0].
//  Sub-module uart_tx_byte:
//   - Parameter CLKS_PER_BIT.
//   - Ports clk, rst_n, tx_start, tx_data[7:0], tx, tx_busy, tx_done.
//  Top of this block: snapshot register, char_idx, byte-select mux, frame FSM.
// TESTING  (sim override CLKS_PER_BIT=10; bench UART receiver samples mid-bit)
//  1. Reset held, then released, no trigger -> uart_tx=1, busy=0, done=0 for 1000 cycles.
//  2. Single dump:
//     - Stimulus: pc=0x00400010, ir=0x8C0A0004, alu=0xDEADBEEF, st=0x0000000F, 1-cycle trigger.
//     - Response: receiver decodes exactly "P=00400010 I=8C0A0004 A=DEADBEEF S=0000000F\r\n" (45 bytes), then one done pulse; busy low after.
//  3. Snapshot:
//     - Stimulus: change all inputs to 0xFFFFFFFF one cycle after trigger.
//     - Response: frame still shows the values latched at trigger.
//  4. Retrigger:
//     - Stimulus: trigger again at byte 10.
//     - Response: ignored; exactly one frame and one done.
//     - Stimulus: trigger in the done cycle.
//     - Response: second full frame starts immediately.
//  5. Timing: each bit is exactly 10 cycles, start=0, stop=1, LSB first, and total frame <=4590 cycles.
//  6. Reset mid-frame:
//     - Stimulus: assert rst_n=0 during byte 20.
//     - Response: uart_tx=1 asynchronously, busy=0.
//     - Stimulus: release, then trigger.
//     - Response: complete frame beginning with 'P' (0x50).

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared constants, types and the nibble-to-ASCII helper for the debug UART dump.
// Latency: n/a (combinational helpers and type definitions only).
// Backpressure: n/a.
package dbg_pkg;

  // Printable characters used to build the dump line
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // "P=xxxxxxxx I=xxxxxxxx A=xxxxxxxx S=xxxxxxxx\r\n"
  localparam int         FRAME_LEN = 45;
  localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);
  localparam logic [5:0] CR_IDX    = 6'(FRAME_LEN - 2);

  // Each "T=xxxxxxxx " field spans 11 characters
  localparam logic [5:0] FIELD_I_BASE = 6'd11;
  localparam logic [5:0] FIELD_A_BASE = 6'd22;
  localparam logic [5:0] FIELD_S_BASE = 6'd33;

  // Debug words captured together on an accepted trigger
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] st;
  } snap_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_LOAD,
    F_SEND,
    F_FINISH
  } frame_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter: start bit, 8 data bits LSB first, one stop bit.
// Latency: line drops 1 cycle after tx_start; tx_done on the last stop-bit cycle (10*CLKS_PER_BIT cycles).
// Backpressure: tx_start is only honoured while idle; callers watch tx_busy/tx_done.
module uart_tx_byte
  import dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;

  logic bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign tx      = tx_q;
  assign tx_busy = (state_q != B_IDLE);
  assign tx_done = (state_q == B_STOP) && bit_end;

  // Next-state: bit timing, data shifting and the registered line level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      B_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (tx_start) begin
          state_d = B_START;
          shreg_d = tx_data;
          tx_d    = 1'b0;
        end
      end
      B_START: begin
        if (bit_end) begin
          state_d = B_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = B_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = B_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = B_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset parks the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/dbg_uart_dump.sv
// Snapshots PC/IR/ALUOut/status on trigger and streams them as one 45-byte ASCII hex line over UART 8N1.
// Latency: start bit 1 cycle after the accepting edge; frame 45*(10*CLKS_PER_BIT+1) cycles, done 1 cycle later.
// Backpressure: none upstream; a trigger while busy is dropped, one in the done cycle starts a new frame.
module dbg_uart_dump
  import dbg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [31:0] pc_dbg,
  input  logic [31:0] ir_dbg,
  input  logic [31:0] aluout_dbg,
  input  logic [31:0] status_dbg,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  frame_state_e state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  snap_t        snap_q, snap_d;

  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;

  logic [31:0] word;
  logic [7:0]  tag;
  logic [5:0]  pos;
  logic [3:0]  nib;

  // Field decode: which word and tag the current character belongs to, and its offset in the field
  always_comb begin
    word = snap_q.pc;
    tag  = ASCII_P;
    pos  = idx_q;
    if (idx_q >= FIELD_S_BASE) begin
      word = snap_q.st;
      tag  = ASCII_S;
      pos  = idx_q - FIELD_S_BASE;
    end else if (idx_q >= FIELD_A_BASE) begin
      word = snap_q.alu;
      tag  = ASCII_A;
      pos  = idx_q - FIELD_A_BASE;
    end else if (idx_q >= FIELD_I_BASE) begin
      word = snap_q.ir;
      tag  = ASCII_I;
      pos  = idx_q - FIELD_I_BASE;
    end
  end

  // Nibble select within a field, most significant nibble first
  always_comb begin
    nib = 4'h0;
    case (pos)
      6'd2:    nib = word[31:28];
      6'd3:    nib = word[27:24];
      6'd4:    nib = word[23:20];
      6'd5:    nib = word[19:16];
      6'd6:    nib = word[15:12];
      6'd7:    nib = word[11:8];
      6'd8:    nib = word[7:4];
      6'd9:    nib = word[3:0];
      default: nib = 4'h0;
    endcase
  end

  // Byte-select mux: tag, '=', eight hex digits, then separator or line ending
  always_comb begin
    tx_data = ASCII_SP;
    case (pos)
      6'd0:                               tx_data = tag;
      6'd1:                               tx_data = ASCII_EQ;
      6'd2, 6'd3, 6'd4, 6'd5,
      6'd6, 6'd7, 6'd8, 6'd9:             tx_data = hex_ascii(nib);
      6'd10:   tx_data = (idx_q == CR_IDX) ? ASCII_CR : ASCII_SP;
      6'd11:                              tx_data = ASCII_LF;
      default:                            tx_data = ASCII_SP;
    endcase
  end

  // Frame FSM: accept/snapshot, hand each character to the byte sender, signal completion
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    tx_start = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      F_IDLE, F_FINISH: begin
        done    = (state_q == F_FINISH);
        state_d = F_IDLE;
        if (trigger) begin
          snap_d  = '{pc: pc_dbg, ir: ir_dbg, alu: aluout_dbg, st: status_dbg};
          idx_d   = '0;
          state_d = F_LOAD;
        end
      end
      F_LOAD: begin
        busy = 1'b1;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = F_SEND;
        end
      end
      F_SEND: begin
        busy = 1'b1;
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = F_FINISH;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = F_LOAD;
          end
        end
      end
      default: begin
        state_d = F_IDLE;
      end
    endcase
  end

  // Frame state, character index and snapshot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (uart_tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

endmodule
